// File: rtl/oc_acc_pkg.sv
// Shared types and helpers for the frame ones-count accumulator.
package oc_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int unsigned POP_W = 3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/oc_frame_acc_ones_count7.sv
// Combinational 7-input ones count, same function as the upstream stage.
module ones_count7 (
    input  logic [6:0] data_i,
    output logic [2:0] cnt_o
);

    assign cnt_o = {2'b00, data_i[6]} + {2'b00, data_i[5]} + {2'b00, data_i[4]}
                 + {2'b00, data_i[3]} + {2'b00, data_i[2]} + {2'b00, data_i[1]}
                 + {2'b00, data_i[0]};

endmodule

// File: rtl/oc_frame_acc.sv
// Sums per-word ones counts over a frame (full or flushed) and holds the result
// on a valid/ready output; OC_ACC_MAXWORD_EN adds a per-frame max-count output.
module oc_frame_acc
    import oc_acc_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned THRESH    = 28,
    localparam int unsigned SUM_W    = clog2(7 * FRAME_LEN + 1),
    localparam int unsigned CNT_W    = clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_words,
`ifdef OC_ACC_MAXWORD_EN
    output logic [POP_W-1:0] out_max,
`endif
    output logic             out_over
);

    acc_state_e       state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_words_q, out_words_d;
    logic             out_over_q, out_over_d;

    logic [POP_W-1:0] pop;
    logic             accept;
    logic             last_word;
    logic             do_result;
    logic [CNT_W-1:0] eff_cnt;
    logic [SUM_W-1:0] acc_sum;

    ones_count7 u_pop (
        .data_i (in_data),
        .cnt_o  (pop)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (idx_q == CNT_W'(FRAME_LEN - 1));
    assign eff_cnt   = idx_q + CNT_W'(accept);
    assign acc_sum   = acc_q + (accept ? SUM_W'(pop) : SUM_W'(0));
    // A flush with nothing collected yet produces no result.
    assign do_result = in_ready && (last_word || (flush && (eff_cnt != '0)));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_sum_d   = out_sum_q;
        out_words_d = out_words_q;
        out_over_d  = out_over_q;
        case (state_q)
            ACCUM: begin
                if (do_result) begin
                    out_sum_d   = acc_sum;
                    out_words_d = eff_cnt;
                    out_over_d  = (32'(acc_sum) >= 32'(THRESH));
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = HOLD;
                end else if (accept) begin
                    acc_d = acc_sum;
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            idx_q       <= '0;
            out_sum_q   <= '0;
            out_words_q <= '0;
            out_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_sum_q   <= out_sum_d;
            out_words_q <= out_words_d;
            out_over_q  <= out_over_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_words = out_words_q;
    assign out_over  = out_over_q;

`ifdef OC_ACC_MAXWORD_EN
    logic [POP_W-1:0] max_q, max_d;
    logic [POP_W-1:0] out_max_q, out_max_d;
    logic [POP_W-1:0] max_new;

    assign max_new = (accept && (pop > max_q)) ? pop : max_q;

    always_comb begin
        max_d     = max_q;
        out_max_d = out_max_q;
        if (do_result) begin
            out_max_d = max_new;
            max_d     = '0;
        end else if (accept) begin
            max_d = max_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q     <= '0;
            out_max_q <= '0;
        end else begin
            max_q     <= max_d;
            out_max_q <= out_max_d;
        end
    end

    assign out_max = out_max_q;
`endif

endmodule

// File: tb/tb_oc_frame_acc.sv
// Scoreboard bench for oc_frame_acc: directed frames push expected results, a monitor checks each handshake.
module tb_oc_frame_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sum;
    logic [3:0] out_words;
    logic       out_over;
`ifdef OC_ACC_MAXWORD_EN
    logic [2:0] out_max;
`endif

    typedef struct {
        int sum;
        int words;
        int over;
        int mx;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    oc_frame_acc #(.FRAME_LEN(8), .THRESH(28)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_words (out_words),
`ifdef OC_ACC_MAXWORD_EN
        .out_max   (out_max),
`endif
        .out_over  (out_over)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp  = n_cmp + 1;
                n_fail = n_fail + 1;
                $display("FAIL unexpected_result: got sum %0d words %0d, expected none", out_sum, out_words);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("res_sum", int'(out_sum), e.sum);
                check("res_words", int'(out_words), e.words);
                check("res_over", int'(out_over), e.over);
`ifdef OC_ACC_MAXWORD_EN
                check("res_max", int'(out_max), e.mx);
`endif
            end
        end
    end

    task automatic push(input int s, input int w, input int o, input int m);
        exp_t e;
        e.sum = s; e.words = w; e.over = o; e.mx = m;
        q.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    // Present one word (optionally with flush) and hold it until accepted.
    task automatic send(input logic [6:0] d, input logic fl);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_n(input logic [6:0] d, input int n);
        for (int i = 0; i < n; i++) send(d, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_words", int'(out_words), 0);
        check("rst_out_over", int'(out_over), 0);

        // Full frame of all-ones: result visible right after the last edge, valid for one cycle.
        push(56, 8, 1, 7);
        send_n(7'h7F, 8);
        check("full_valid_hi", int'(out_valid), 1);
        check("full_ready_lo", int'(in_ready), 0);
        @(posedge clk); #1;
        check("full_valid_lo", int'(out_valid), 0);
        check("full_ready_hi", int'(in_ready), 1);

        push(8, 8, 0, 1);
        send_n(7'b1000000, 8);

        // Flush on the third word includes that word.
        push(10, 3, 0, 7);
        send(7'h7F, 1'b0);
        send(7'h01, 1'b0);
        send(7'h03, 1'b1);

        // Flush with nothing collected is ignored.
        wait_ready();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("empty_flush_no_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end

        // Threshold boundary: 28 sets the flag, 27 does not.
        push(28, 4, 1, 7);
        send_n(7'h7F, 3);
        send(7'h7F, 1'b1);
        push(27, 4, 0, 7);
        send_n(7'h7F, 3);
        send(7'h3F, 1'b1);

        // Flush on the final word of a full frame yields a single result.
        push(8, 8, 0, 1);
        send_n(7'h01, 7);
        send(7'h01, 1'b1);

        // Backpressure: result held stable, flush in HOLD ignored.
        wait_ready();
        out_ready = 1'b0;
        push(8, 8, 0, 1);
        send_n(7'h01, 8);
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_sum", int'(out_sum), 8);
            check("bp_out_words", int'(out_words), 8);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_keep_sum", int'(out_sum), 8);
        push(2, 1, 0, 2);
        send(7'h03, 1'b1);

        // Reset mid-frame discards the partial frame and clears outputs.
        wait_ready();
        send_n(7'h7F, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_sum", int'(out_sum), 0);
        check("mid_rst_out_words", int'(out_words), 0);
        check("mid_rst_out_over", int'(out_over), 0);
`ifdef OC_ACC_MAXWORD_EN
        check("mid_rst_out_max", int'(out_max), 0);
`endif
        push(32, 8, 1, 4);
        send_n(7'h0F, 8);

        // Running maximum frame.
        push(10, 8, 0, 6);
        send(7'h01, 1'b0);
        send(7'h3F, 1'b0);
        send(7'h07, 1'b0);
        send_n(7'h00, 5);

        repeat (5) @(posedge clk);
        #1 check("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oc_frame_acc.md
# oc_frame_acc

Frame-level ones-count accumulator placed directly downstream of the 7-input ones-count stage. It accepts a stream of 7-bit words over a valid/ready handshake and counts the ones in each word. It sums those counts over a frame of FRAME_LEN words, or a shorter frame ended by flush. It then presents the frame total, word count and threshold flag on a held output handshake.

## Interface
- FRAME_LEN, 8: words per full frame; must be ≥1.
- THRESH, 28: out_over asserts when frame sum ≥ THRESH.
- SUM_W (derived localparam): clog2(7*FRAME_LEN+1). Value 6 at default.
- CNT_W (derived localparam): clog2(FRAME_LEN+1). Value 4 at default.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  7  input word. Bit 6 is input a, bit 0 is input g.
- flush  in  1  ends the current frame early.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  SUM_W  total ones in the frame.
- out_words  out  CNT_W  words in the frame.
- out_over  out  1  out_sum ≥ THRESH.
- out_max  out  3  maximum per-word count. Present only with OC_ACC_MAXWORD_EN.

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- Reset values: acc=0, idx=0, out_valid=0, out_sum=0, out_words=0, out_over=0, out_max=0. in_ready is 1 in the first cycle after reset.
- in_ready = (state==ACCUM). It is combinational from state only and never depends on in_valid.
- A word is accepted when in_valid && in_ready at a clock edge. pop = ones_count7(in_data), range 0..7, zero-extended to SUM_W.
- ACCUM, word accepted and idx≠FRAME_LEN-1: acc += pop, idx += 1.
- ACCUM, word accepted and idx==FRAME_LEN-1: register the result (out_sum = acc+pop, out_words = FRAME_LEN, out_over). Clear acc and idx. Go to HOLD.
- ACCUM, flush asserted:
  - The effective count is idx plus 1 if a word is accepted in the same cycle. That word is included in the result.
  - If the effective count >0: register the partial result with out_words = effective count, clear acc and idx, go to HOLD.
  - If the effective count ==0: ignore flush and stay in ACCUM.
- HOLD: out_valid=1 and all out_* are stable. When out_ready is high, go to ACCUM with out_valid=0 in the next cycle. Output registers keep their last values after the handoff.
- flush in HOLD is ignored. The flag is not remembered.
- The sum never overflows: SUM_W covers 7*FRAME_LEN.
- out_over is computed from the registered sum using an unsigned compare.

## Timing
- Word → acc: 1 cycle.
- Last word, or flush, accepted at edge N → out_valid high from edge N, visible in cycle N+1.
- Result handshake at edge M → in_ready high from edge M. The first word of the next frame can be accepted at edge M+1.
- Throughput: at most FRAME_LEN words per FRAME_LEN+1 cycles when out_ready is held high.
- Reset mid-frame or mid-HOLD: the partial frame is discarded and no result is emitted.

## Configuration
- OC_ACC_MAXWORD_EN defined:
  - Adds a 3-bit per-frame running maximum of pop, including the final word.
  - The maximum is registered to out_max with the result and cleared with acc.
- OC_ACC_MAXWORD_EN undefined: the out_max port and its register are absent. All other behaviour is identical.

## Structure
- Package oc_acc_pkg holds:
  - the state enum (ACCUM, HOLD);
  - a localparam POP_W=3;
  - a clog2 helper function, used for SUM_W and CNT_W.
- Sub-module ones_count7: purely combinational. Takes a 7-bit input and produces a 3-bit output equal to the number of ones. It has the same function as the upstream ones-count stage.
- Top level: state register, acc, idx, output registers.

## Test plan
- 8 words of 7'h7F with out_ready=1 → out_sum=56, out_words=8, out_over=1. out_valid is high for exactly 1 cycle.
- 8 words of 7'b1000000 → out_sum=8, out_over=0. Words 1..7 give pop=1 each, so acc steps 1..7.
- Flush: 7'h7F, 7'h01, then 7'h03 with flush in the same cycle → out_sum=10, out_words=3. Flush with idx=0 and no word accepted → no result.
- Backpressure: result pending with out_ready=0 for 5 cycles → in_ready=0, outputs unchanged. out_ready=1 → in_ready=1 in the next cycle, and the next frame starts with acc=0.
- rst asserted after 4 words → all outputs 0, state ACCUM. A following full frame of 7'h0F gives out_sum=32.
- With OC_ACC_MAXWORD_EN: words 7'h01, 7'h3F, 7'h07, then 5× 7'h00 → out_max=6 and out_sum=10.
